pallet_ctrl: RTL and testbench

Port-A controller for the VGA 256×12-bit palette RAM (the `pallet` block).
- Shares palette port A between the CPU bus and a hardware sweep engine.
- The sweep engine clears the whole palette to one colour and, when configured, fades it.
- Port B (scanout read) does not pass through this block.
- Sits between the VGA peripheral register decoder and the palette instance.

---
 rtl/pallet_ctrl.sv | 158 +++++++++++++++
 tb/tb_pallet_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pallet_ctrl.sv
// pallet_ctrl: port-A controller for the 256x12 VGA palette RAM.
//
// Shares palette port A between the CPU bus and a sweep engine. The sweep
// engine fills every entry with one colour, or (optionally) fades every entry
// by one step per colour nibble. CPU accesses always win; a sweep step that
// collides with a CPU access is stalled for that cycle.
//
// Optional feature: define PALLET_FADE_EN to compile in the fade sweep. When
// undefined, fade_start is accepted on the port but has no effect.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU access request (one access per cycle)
//   cpu_ack, cpu_rdata       registered completion and read data
//   fill_start, fill_color   start a fill sweep with the given colour
//   fade_start               start a fade sweep (PALLET_FADE_EN only)
//   busy, done               sweep in progress / one-cycle completion pulse
//   pal_wena/addra/din       palette port A controls
//   pal_douta                palette port A combinational read data
module pallet_ctrl #(
  parameter int unsigned ENTRIES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [11:0] cpu_rdata,
  input  logic        fill_start,
  input  logic [11:0] fill_color,
  input  logic        fade_start,
  output logic        busy,
  output logic        done,
  output logic        pal_wena,
  output logic [7:0]  pal_addra,
  output logic [11:0] pal_din,
  input  logic [11:0] pal_douta
);

  localparam logic [7:0] LastIdx = 8'(ENTRIES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFade
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [11:0] color_q, color_d;
  logic        ack_q;
  logic [11:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        sweep_step;

`ifdef PALLET_FADE_EN
  // Per-nibble decrement that sticks at zero.
  function automatic logic [11:0] sat_dec(input logic [11:0] c);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (c[i*4 +: 4] == 4'h0) ? 4'h0 : c[i*4 +: 4] - 4'h1;
    end
    return r;
  endfunction
`else
  logic unused_fade_start;
  assign unused_fade_start = fade_start;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    color_d    = color_q;
    done_d     = 1'b0;
    sweep_step = 1'b0;
    pal_wena   = 1'b0;
    pal_addra  = 8'h00;
    pal_din    = 12'h000;

    case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d = StFill;
          idx_d   = 8'h00;
          color_d = fill_color;
`ifdef PALLET_FADE_EN
        end else if (fade_start) begin
          state_d = StFade;
          idx_d   = 8'h00;
`endif
        end
      end
      StFill: begin
        if (!cpu_req) begin
          pal_wena   = 1'b1;
          pal_addra  = idx_q;
          pal_din    = color_q;
          sweep_step = 1'b1;
        end
      end
`ifdef PALLET_FADE_EN
      StFade: begin
        // With no CPU access, port A reads idx_q, so pal_douta is the old entry.
        if (!cpu_req) begin
          pal_wena   = 1'b1;
          pal_addra  = idx_q;
          pal_din    = sat_dec(pal_douta);
          sweep_step = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (sweep_step) begin
      idx_d = idx_q + 8'h01;
      if (idx_q == LastIdx) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    // CPU owns port A whenever it requests.
    if (cpu_req) begin
      pal_wena  = cpu_we;
      pal_addra = cpu_addr;
      pal_din   = cpu_wdata;
    end
  end

  assign rdata_d = (cpu_req && !cpu_we) ? pal_douta : rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 8'h00;
      color_q <= 12'h000;
      ack_q   <= 1'b0;
      rdata_q <= 12'h000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      ack_q   <= cpu_req;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign cpu_ack   = ack_q;
  assign cpu_rdata = rdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_pallet_ctrl.sv
// Testbench for pallet_ctrl: palette RAM model plus a cycle-level reference of
// the palette contents, sweep progress and CPU responses.
module tb_pallet_ctrl;

`ifdef PALLET_FADE_EN
  localparam bit FadeEn = 1'b1;
`else
  localparam bit FadeEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [11:0] cpu_wdata;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        fill_start, fade_start;
  logic [11:0] fill_color;
  logic        busy, done;
  logic        pal_wena;
  logic [7:0]  pal_addra;
  logic [11:0] pal_din, pal_douta;

  int checks = 0;
  int errors = 0;

  // Palette RAM (port A only): combinational read, write on rising edge.
  logic [11:0] pal_mem [256];
  assign pal_douta = pal_mem[pal_addra];
  always @(posedge clk) if (pal_wena) pal_mem[pal_addra] <= pal_din;

  always #5 clk = ~clk;

  pallet_ctrl #(.ENTRIES(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .fade_start(fade_start),
    .busy      (busy),
    .done      (done),
    .pal_wena  (pal_wena),
    .pal_addra (pal_addra),
    .pal_din   (pal_din),
    .pal_douta (pal_douta)
  );

  // Reference model: 0 = idle, 1 = filling, 2 = fading.
  logic [11:0] ref_mem [256];
  int          m_mode;
  int          m_pos;
  logic [11:0] m_color;
  logic        m_ack, m_done;
  logic [11:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] fade_of(input logic [11:0] c);
    int r, g, b;
    r = int'(c[11:8]);
    g = int'(c[7:4]);
    b = int'(c[3:0]);
    r = (r > 0) ? r - 1 : 0;
    g = (g > 0) ? g - 1 : 0;
    b = (b > 0) ? b - 1 : 0;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    fill_start = 0; fade_start = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_ack = 0; m_done = 0; m_rdata = 0;
  endtask

  // One clock cycle with the currently driven inputs; checks port A before
  // the edge and the registered outputs after it.
  task automatic cycle();
    logic        ew, nack, nd;
    logic [7:0]  ea;
    logic [11:0] ed, nrd;
    #1;
    if (cpu_req) begin
      ew = cpu_we; ea = cpu_addr; ed = cpu_wdata;
    end else if (m_mode == 1) begin
      ew = 1; ea = 8'(m_pos); ed = m_color;
    end else if (m_mode == 2) begin
      ew = 1; ea = 8'(m_pos); ed = fade_of(ref_mem[m_pos]);
    end else begin
      ew = 0; ea = 0; ed = 0;
    end
    check("pal_wena", 32'(pal_wena), 32'(ew));
    check("pal_addra", 32'(pal_addra), 32'(ea));
    check("pal_din", 32'(pal_din), 32'(ed));

    nack = cpu_req;
    nrd  = (cpu_req && !cpu_we) ? ref_mem[cpu_addr] : m_rdata;
    nd   = 0;
    if (cpu_req && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    if (m_mode == 0) begin
      if (fill_start) begin
        m_mode = 1; m_pos = 0; m_color = fill_color;
      end else if (fade_start && FadeEn) begin
        m_mode = 2; m_pos = 0;
      end
    end else if (!cpu_req) begin
      ref_mem[m_pos] = ed;
      if (m_pos == 255) begin
        m_mode = 0; nd = 1;
      end
      m_pos = (m_pos + 1) % 256;
    end

    @(posedge clk); #1;
    m_ack = nack; m_rdata = nrd; m_done = nd;
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("done", 32'(done), 32'(m_done));
    check("cpu_ack", 32'(cpu_ack), 32'(m_ack));
    check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [11:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
    cycle();
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, input string tag, input logic [11:0] exp);
    cpu_req = 1; cpu_we = 0; cpu_addr = a;
    cycle();
    check(tag, 32'(cpu_rdata), 32'(exp));
    cpu_req = 0;
  endtask

  // Called in cycle 1 of a sweep. Counts busy cycles and the cycle number on
  // which done appears; optionally a CPU write of 0xFFF to 0x05 at cycle stall_at.
  task automatic run_sweep(input int stall_at, output int bc, output int n);
    bc = 0;
    n  = 1;
    while (done !== 1'b1 && n < 600) begin
      if (busy === 1'b1) bc++;
      if (n == stall_at) begin
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h05; cpu_wdata = 12'hFFF;
      end else begin
        set_idle();
      end
      cycle();
      n++;
    end
    set_idle();
  endtask

  int bc, n, dones;

  initial begin
    set_idle();
    fill_color = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 12'h000;
    for (int i = 0; i < 256; i++) pal_mem[i] = 12'h000;
    model_reset();
    rst_n = 0;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack", 32'(cpu_ack), 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    check("rst_wena", 32'(pal_wena), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);

    // CPU write then read-after-write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 12'hABC;
    cycle();
    check("wr_ack", 32'(cpu_ack), 1);
    cpu_we = 0;
    cycle();
    check("rd_ack", 32'(cpu_ack), 1);
    check("rd_data", 32'(cpu_rdata), 32'h0ABC);
    set_idle();
    cycle();
    check("ack_drop", 32'(cpu_ack), 0);

    // Unstalled fill.
    fill_start = 1; fill_color = 12'h123;
    cycle();
    run_sweep(0, bc, n);
    check("fill_busy_cycles", 32'(bc), 256);
    check("fill_done_cycle", 32'(n), 257);
    cycle();
    check("fill_done_once", 32'(done), 0);
    cpu_rd(8'h00, "fill_e0", 12'h123);
    cpu_rd(8'h80, "fill_e128", 12'h123);
    cpu_rd(8'hFF, "fill_e255", 12'h123);

    // Fill stalled by a CPU write at idx 3.
    fill_start = 1; fill_color = 12'h3C5;
    cycle();
    run_sweep(4, bc, n);
    check("stall_busy_cycles", 32'(bc), 257);
    check("stall_done_cycle", 32'(n), 258);
    cycle();
    cpu_rd(8'h05, "stall_e5", 12'h3C5);
    cpu_rd(8'h04, "stall_e4", 12'h3C5);

    // Simultaneous starts give a fill; a start while busy is ignored.
    fill_start = 1; fade_start = 1; fill_color = 12'h7E1;
    cycle();
    dones = 0;
    for (int i = 1; i < 300; i++) begin
      set_idle();
      if (i == 100) begin
        fill_start = 1; fill_color = 12'h000;
      end
      cycle();
      if (done === 1'b1) dones++;
    end
    set_idle();
    check("busy_start_dones", 32'(dones), 1);
    cpu_rd(8'h00, "both_e0", 12'h7E1);
    cpu_rd(8'hC8, "both_e200", 12'h7E1);

    // Fade.
    cpu_wr(8'h20, 12'h0F1);
    cpu_wr(8'h21, 12'h000);
    fade_start = 1;
    cycle();
    fade_start = 0;
`ifdef PALLET_FADE_EN
    run_sweep(0, bc, n);
    check("fade_done_cycle", 32'(n), 257);
    cycle();
    cpu_rd(8'h20, "fade_0f1", 12'h0E0);
    cpu_rd(8'h21, "fade_000", 12'h000);
    cpu_rd(8'h00, "fade_7e1", 12'h6D0);
`else
    check("nofade_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) cycle();
    cpu_rd(8'h20, "nofade_e20", 12'h0F1);
`endif

    // Reset in the middle of a fill.
    fill_start = 1; fill_color = 12'h456;
    cycle();
    set_idle();
    for (int i = 0; i < 50; i++) cycle();
    #3 rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_ack", 32'(cpu_ack), 0);
    check("mid_rst_rdata", 32'(cpu_rdata), 0);
    check("mid_rst_wena", 32'(pal_wena), 0);
    check("mid_rst_addra", 32'(pal_addra), 0);
    check("mid_rst_din", 32'(pal_din), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check("mid_rst_post_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) cycle();
    check("mid_rst_no_done", 32'(done), 0);
    cpu_rd(8'h0A, "mid_rst_e10", 12'h456);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      cpu_req    = ($urandom_range(0, 3) == 0);
      cpu_we     = $urandom_range(0, 1) == 1;
      cpu_addr   = 8'($urandom);
      cpu_wdata  = 12'($urandom);
      fill_start = ($urandom_range(0, 199) == 0);
      fade_start = ($urandom_range(0, 199) == 0);
      fill_color = 12'($urandom);
      cycle();
    end
    set_idle();
    for (int i = 0; i < 1000 && m_mode != 0; i++) cycle();
    check("drain_busy", 32'(busy), 0);
    for (int a = 0; a < 256; a++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'(a);
      cycle();
    end
    set_idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
